// File: rtl/dem_pkg.sv
// Shared DEM definitions: LFSR width, default seed and feedback taps.
// The switching-block and tree-level code use the same constants.
package dem_pkg;
    localparam int LFSR_W = 16;
    typedef logic [LFSR_W-1:0] lfsr_t;
    localparam lfsr_t LFSR_SEED_DEF = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shift form
    localparam int TAP0 = 0;
    localparam int TAP1 = 2;
    localparam int TAP2 = 3;
    localparam int TAP3 = 5;
endpackage

// File: rtl/dem_lfsr_step.sv
// Combinational unroll of STEPS Fibonacci LFSR shifts.
// Bit k of o_bits is the bit shifted out by step k.
module dem_lfsr_step
    import dem_pkg::*;
#(
    parameter int STEPS = 5
) (
    input  lfsr_t            i_state,
    output lfsr_t            o_state,
    output logic [STEPS-1:0] o_bits
);
    always_comb begin
        lfsr_t w_acc;
        w_acc  = i_state;
        o_bits = '0;
        for (int k = 0; k < STEPS; k++) begin
            o_bits[k] = w_acc[0];
            w_acc     = {w_acc[TAP0] ^ w_acc[TAP1] ^ w_acc[TAP2] ^ w_acc[TAP3],
                         w_acc[LFSR_W-1:1]};
        end
        o_state = w_acc;
    end
endmodule

// File: rtl/dem_pn_generator.sv
// Per-sample pseudorandom control bits for the DEM switching-block tree.
// Priority at each edge: reset > lock-up recovery > seed load > sample.
module dem_pn_generator
    import dem_pkg::*;
#(
    parameter int    NUM_SW   = 5,
    parameter lfsr_t SEED_DEF = LFSR_SEED_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sample_en_i,
    input  logic              seed_load_i,
    input  lfsr_t             seed_i,
    output logic [NUM_SW-1:0] pn_seq_o,
    output logic              pn_valid_o,
    output logic              lockup_o
);
    lfsr_t             r_lfsr;
    lfsr_t             w_next;
    logic [NUM_SW-1:0] w_bits;

    dem_lfsr_step #(.STEPS(NUM_SW)) u_step (
        .i_state (r_lfsr),
        .o_state (w_next),
        .o_bits  (w_bits)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_lfsr     <= SEED_DEF;
            pn_seq_o   <= '0;
            pn_valid_o <= 1'b0;
            lockup_o   <= 1'b0;
        end else begin
            pn_valid_o <= 1'b0;
            lockup_o   <= 1'b0;
            // All-zero is only reachable via a zero seed; recover and drop any sample.
            if (r_lfsr == '0) begin
                r_lfsr   <= SEED_DEF;
                lockup_o <= 1'b1;
            end else if (seed_load_i) begin
                r_lfsr <= seed_i;
            end else if (sample_en_i) begin
                r_lfsr     <= w_next;
                pn_seq_o   <= w_bits;
                pn_valid_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dem_pn_generator.sv
// Directed scoreboard bench for dem_pn_generator (NUM_SW=5 main, NUM_SW=1 for the period run).
module tb_dem_pn_generator;
    import dem_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       sen, sld, sen1;
    lfsr_t      seed;
    logic [4:0] pn;
    logic [0:0] pn1;
    logic       pv, lk, pv1, lk1;

    int vectors     = 0;
    int miscompares = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    dem_pn_generator #(.NUM_SW(5)) u_dut (
        .clk_i(clk), .reset_i(rst), .sample_en_i(sen), .seed_load_i(sld),
        .seed_i(seed), .pn_seq_o(pn), .pn_valid_o(pv), .lockup_o(lk)
    );

    dem_pn_generator #(.NUM_SW(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .sample_en_i(sen1), .seed_load_i(1'b0),
        .seed_i(16'h0000), .pn_seq_o(pn1), .pn_valid_o(pv1), .lockup_o(lk1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pn_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && pv) begin
            if (exp_q.size() == 0) check("pn_valid_unexpected", 32'(pv), 32'd0);
            else check("pn_seq", 32'(pn), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [4:0] exp);
        exp_q.push_back(exp);
        sen = 1'b1;
        tick();
        sen = 1'b0;
    endtask

    initial begin
        int  ones;
        bit  early;
        rst = 1'b1; sen = 1'b0; sld = 1'b0; sen1 = 1'b0; seed = '0;
        #12;
        check("reset_pn_seq", 32'(pn), 32'd0);
        check("reset_pn_valid", 32'(pv), 32'd0);
        check("reset_lockup", 32'(lk), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Period run on the single-bit instance
        ones = 0; early = 1'b0;
        sen1 = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            tick();
            ones += int'(pn1[0]);
            if (i < 65534 && u_dut1.r_lfsr == 16'hACE1) early = 1'b1;
            if (lk1) early = 1'b1;
        end
        sen1 = 1'b0;
        check("period_no_early_repeat", 32'(early), 32'd0);
        check("period_state_wrap", 32'(u_dut1.r_lfsr), 32'hACE1);
        check("period_ones", 32'(ones), 32'd32768);
        check("period_zeros", 32'(65535 - ones), 32'd32767);

        // Scenario 1: first strobe after reset
        strobe(5'b00001);
        tick();
        check("pn_valid_single_pulse", 32'(pv), 32'd0);
        check("pn_seq_hold", 32'(pn), 32'h01);

        // Scenario 2: another sample, then reseed to the default seed
        strobe(5'b00111);
        sld = 1'b1; seed = 16'hACE1;
        tick();
        sld = 1'b0;
        check("seed_load_no_valid", 32'(pv), 32'd0);
        strobe(5'b00001);

        // Scenario 3: seed load beats a simultaneous sample
        sld = 1'b1; sen = 1'b1; seed = 16'h1234;
        tick();
        sld = 1'b0; sen = 1'b0;
        check("seed_prio_no_valid", 32'(pv), 32'd0);
        check("seed_prio_pn_held", 32'(pn), 32'h01);
        strobe(5'b10100);

        // Scenario 4: zero seed -> lock-up recovery, strobe in that cycle dropped
        sld = 1'b1; seed = 16'h0000;
        tick();
        sld = 1'b0; sen = 1'b1;
        check("lockup_not_on_load_edge", 32'(lk), 32'd0);
        tick();
        sen = 1'b0;
        check("lockup_pulse", 32'(lk), 32'd1);
        check("lockup_drop_valid", 32'(pv), 32'd0);
        check("lockup_pn_held", 32'(pn), 32'h14);
        tick();
        check("lockup_one_cycle", 32'(lk), 32'd0);
        // back-to-back strobes from the recovered seed
        strobe(5'b00001);
        strobe(5'b00111);

        // Scenario 6: asynchronous reset between edges
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_pn_seq", 32'(pn), 32'd0);
        check("async_reset_pn_valid", 32'(pv), 32'd0);
        check("async_reset_lockup", 32'(lk), 32'd0);
        #3;
        rst = 1'b0;
        tick();
        strobe(5'b00001);

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
